// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter and its round-robin picker:
//   - arb_state_t : arbiter FSM encoding (free arbitration / locked burst)
//   - clog2()     : elaboration-time width helper for index and counter widths
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Smallest r with 2**r >= value; returns at least 1 so a vector is never
   // declared zero bits wide.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Round-robin priority picker. Searches the request vector starting at i_ptr
// and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   i_req    in  NUM_REQ  request vector
//   i_ptr    in  IDX_W    search start position (highest priority)
//   o_grant  out NUM_REQ  one-hot grant (all zero when no request)
//   o_idx    out IDX_W    index of the winner (0 when no request)
//   o_any    out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_priority_pick
   import ram_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   // w_cand_idx[k] is the requester examined at priority rank k.
   logic [IDX_W-1:0] w_cand_idx [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         // Explicit wrap instead of '%' so non-power-of-two NUM_REQ works.
         assign w_cand_idx[gi] = ((int'(i_ptr) + gi) >= NUM_REQ)
                               ? IDX_W'(int'(i_ptr) + gi - NUM_REQ)
                               : IDX_W'(int'(i_ptr) + gi);
      end
   endgenerate

   always_comb begin
      o_any   = 1'b0;
      o_idx   = '0;
      o_grant = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_any && i_req[w_cand_idx[k]]) begin
            o_any = 1'b1;
            o_idx = w_cand_idx[k];
         end
      end
      if (o_any) begin
         o_grant[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM (async read, sync write) between NUM_REQ
// requesters. Round-robin arbitration with zero-cycle grant, one access per
// cycle, optional bounded lock (burst) of up to MAX_HOLD consecutive grants.
// Read data is registered and returned one cycle after the read grant.
// Ports:
//   i_clock        in  1                    rising-edge clock
//   i_reset_n      in  1                    async active-low reset
//   i_req_valid    in  NUM_REQ              request pending per requester
//   i_req_we       in  NUM_REQ              1=write, 0=read
//   i_req_lock     in  NUM_REQ              keep grant on following cycles
//   i_req_addr     in  NUM_REQ*ADDR_SPACE   requester i at [i*ADDR_SPACE +: ADDR_SPACE]
//   i_req_wdata    in  NUM_REQ*DATA_WIDTH   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready    out NUM_REQ              one-hot grant, access completes this cycle
//   o_rsp_valid    out NUM_REQ              one-hot read data valid
//   o_rsp_data     out DATA_WIDTH           registered read data
//   o_ram_address  out ADDR_SPACE           RAM address
//   o_ram_data     out DATA_WIDTH+1         RAM write data, MSB tied to 0
//   o_ram_wren     out 1                    RAM write enable
//   i_ram_q        in  DATA_WIDTH           RAM combinational read data
// ---------------------------------------------------------------------------
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_SPACE = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_HOLD   = 8
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ-1:0]           i_req_we,
   input  logic [NUM_REQ-1:0]           i_req_lock,
   input  logic [NUM_REQ*ADDR_SPACE-1:0] i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [NUM_REQ-1:0]           o_rsp_valid,
   output logic [DATA_WIDTH-1:0]        o_rsp_data,
   output logic [ADDR_SPACE-1:0]        o_ram_address,
   output logic [DATA_WIDTH:0]          o_ram_data,
   output logic                         o_ram_wren,
   input  logic [DATA_WIDTH-1:0]        i_ram_q
);

   localparam int IDX_W  = clog2(NUM_REQ);
   localparam int HOLD_W = clog2(MAX_HOLD + 1);

   arb_state_t          r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;

   logic [NUM_REQ-1:0]  w_pick_grant;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_pick_any;
   logic [NUM_REQ-1:0]  w_ready;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic                w_gnt_valid;
   logic                w_sel_we;
   logic [IDX_W-1:0]    w_rr_next;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // Grant decision. w_gnt_idx also steers the RAM mux when nothing is
   // granted, so it defaults to the round-robin pointer.
   always_comb begin
      w_ready   = '0;
      w_gnt_idx = r_rr_ptr;
      if (r_state == ST_ARB) begin
         if (w_pick_any) begin
            w_ready   = w_pick_grant;
            w_gnt_idx = w_pick_idx;
         end
      end else if (i_req_valid[r_owner]) begin
         w_ready[r_owner] = 1'b1;
         w_gnt_idx        = r_owner;
      end
      // No access may complete while reset is held, even mid-cycle.
      if (!i_reset_n) begin
         w_ready = '0;
      end
   end

   assign w_gnt_valid = |w_ready;
   assign w_sel_we    = i_req_we[w_gnt_idx];
   assign w_rr_next   = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   assign o_req_ready   = w_ready;
   assign o_ram_address = i_req_addr[w_gnt_idx*ADDR_SPACE +: ADDR_SPACE];
   assign o_ram_data    = {1'b0, i_req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH]};
   assign o_ram_wren    = w_gnt_valid & w_sel_we;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_data    = r_rsp_data;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_ARB;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_hold_cnt  <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         // Response pulse lasts exactly one cycle; data holds otherwise.
         r_rsp_valid <= '0;
         if (w_gnt_valid && !w_sel_we) begin
            r_rsp_valid <= w_ready;
            r_rsp_data  <= i_ram_q;
         end

         case (r_state)
            ST_ARB: begin
               if (w_gnt_valid) begin
                  r_rr_ptr <= w_rr_next;
                  if (i_req_lock[w_gnt_idx] && (MAX_HOLD > 1)) begin
                     r_state    <= ST_LOCKED;
                     r_owner    <= w_gnt_idx;
                     r_hold_cnt <= HOLD_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               // r_rr_ptr already points past the owner, so whoever is next
               // in line wins as soon as the lock ends. An idle owner
               // releases the lock without a grant this cycle.
               if (w_gnt_valid && i_req_lock[r_owner] &&
                   (r_hold_cnt != HOLD_W'(MAX_HOLD - 1))) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end else begin
                  r_state    <= ST_ARB;
                  r_hold_cnt <= '0;
               end
            end
            default: begin
               r_state <= ST_ARB;
            end
         endcase
      end
   end

endmodule
